// File: rtl/csr_exec_unit.sv
// rtl/csr_exec_unit.sv - serialized CSR read-modify-write unit with a small machine-mode CSR file
// Optional mcycle/minstret counters are compiled in with `define CSR_COUNTER_EN.
module csr_exec_unit #(
  parameter int              XLEN       = 64,
  parameter int              PREG_WIDTH = 7,
  parameter int              ROB_WIDTH  = 6,
  parameter logic [XLEN-1:0] HART_ID    = '0,
  parameter logic [XLEN-1:0] MISA_VAL   = 64'h8000_0000_0014_1101
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_en,
  output logic                  issue_ready,
  input  logic [2:0]            issue_op,
  input  logic [11:0]           issue_csrid,
  input  logic [4:0]            issue_imm,
  input  logic                  issue_src_zero,
  input  logic [XLEN-1:0]       issue_rdata,
  input  logic [PREG_WIDTH-1:0] issue_rd,
  input  logic                  issue_we,
  input  logic [ROB_WIDTH:0]    issue_rob_idx,
  input  logic                  redirect,
  input  logic [ROB_WIDTH:0]    redirect_idx,
  input  logic [2:0]            retire_cnt,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [PREG_WIDTH-1:0] wb_rd,
  output logic                  wb_we,
  output logic [XLEN-1:0]       wb_data,
  output logic [ROB_WIDTH:0]    wb_rob_idx,
  output logic                  wb_exc,
  output logic [3:0]            wb_exc_cause
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t                  state_q;
  logic [2:0]              op_q;
  logic [11:0]             csrid_q;
  logic [4:0]              imm_q;
  logic                    src_zero_q;
  logic [XLEN-1:0]         rdata_q;
  logic [PREG_WIDTH-1:0]   rd_q;
  logic                    we_q;
  logic [ROB_WIDTH:0]      rob_q;
  logic [XLEN-1:0]         mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic                    wb_valid_q, wb_we_q, wb_exc_q;
  logic [PREG_WIDTH-1:0]   wb_rd_q;
  logic [XLEN-1:0]         wb_data_q;
  logic [ROB_WIDTH:0]      wb_rob_q;
`ifdef CSR_COUNTER_EN
  logic [XLEN-1:0]         mcycle_q, minstret_q;
`else
  logic                    unused_retire;
  assign unused_retire = ^retire_cnt;
`endif

  logic [ROB_WIDTH:0] op_idx;
  logic               kill, src_zero, is_rw, do_write, implemented, illegal, commit;
  logic [XLEN-1:0]    src, old_val, new_d;

  // Wrap-aware age compare: the MSB flips each time the ROB index wraps.
  function automatic logic older(input logic [ROB_WIDTH:0] a, input logic [ROB_WIDTH:0] b);
    if (a[ROB_WIDTH] != b[ROB_WIDTH]) return a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
    else                              return a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
  endfunction

  always_comb begin
    op_idx      = (state_q == EXEC) ? rob_q : issue_rob_idx;
    kill        = redirect && !older(op_idx, redirect_idx);
    src         = op_q[2] ? {{(XLEN-5){1'b0}}, imm_q} : rdata_q;
    src_zero    = op_q[2] ? (imm_q == 5'd0) : src_zero_q;
    is_rw       = (op_q[1:0] == 2'b01);
    do_write    = is_rw || !src_zero;
    implemented = 1'b1;
    old_val     = '0;
    case (csrid_q)
      12'h305: old_val = mtvec_q;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'h301: old_val = MISA_VAL;
      12'hF14: old_val = HART_ID;
`ifdef CSR_COUNTER_EN
      12'hB00: old_val = mcycle_q;
      12'hB02: old_val = minstret_q;
`endif
      default: implemented = 1'b0;
    endcase
    illegal = !implemented || (op_q[1:0] == 2'b00) || (do_write && csrid_q[11:10] == 2'b11);
    case (op_q[1:0])
      2'b01:   new_d = src;
      2'b10:   new_d = old_val | src;
      default: new_d = old_val & ~src;
    endcase
    commit = !illegal && do_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      csrid_q    <= '0;
      imm_q      <= '0;
      src_zero_q <= 1'b0;
      rdata_q    <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      rob_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_exc_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_rob_q   <= '0;
`ifdef CSR_COUNTER_EN
      mcycle_q   <= '0;
      minstret_q <= '0;
`endif
    end else begin
`ifdef CSR_COUNTER_EN
      mcycle_q   <= mcycle_q + 1'b1;
      minstret_q <= minstret_q + {{(XLEN-3){1'b0}}, retire_cnt};
`endif
      case (state_q)
        IDLE: begin
          if (issue_en && !kill) begin
            op_q       <= issue_op;
            csrid_q    <= issue_csrid;
            imm_q      <= issue_imm;
            src_zero_q <= issue_src_zero;
            rdata_q    <= issue_rdata;
            rd_q       <= issue_rd;
            we_q       <= issue_we;
            rob_q      <= issue_rob_idx;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          if (kill) begin
            state_q <= IDLE;
          end else begin
            // Later assignments here win over the free-running counter increments above.
            if (commit) begin
              case (csrid_q)
                12'h305: mtvec_q    <= new_d & ~{{(XLEN-2){1'b0}}, 2'b10};
                12'h340: mscratch_q <= new_d;
                12'h341: mepc_q     <= new_d & ~{{(XLEN-1){1'b0}}, 1'b1};
                12'h342: mcause_q   <= new_d;
`ifdef CSR_COUNTER_EN
                12'hB00: mcycle_q   <= new_d;
                12'hB02: minstret_q <= new_d;
`endif
                default: ;
              endcase
            end
            wb_valid_q <= 1'b1;
            wb_exc_q   <= illegal;
            wb_data_q  <= illegal ? '0 : old_val;
            wb_we_q    <= !illegal && we_q;
            wb_rd_q    <= rd_q;
            wb_rob_q   <= rob_q;
            state_q    <= WB;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign issue_ready  = (state_q == IDLE);
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_we        = wb_we_q;
  assign wb_data      = wb_data_q;
  assign wb_rob_idx   = wb_rob_q;
  assign wb_exc       = wb_exc_q;
  assign wb_exc_cause = wb_exc_q ? 4'd2 : 4'd0;

endmodule

// File: tb/tb_csr_exec_unit.sv
// tb/tb_csr_exec_unit.sv - directed self-checking bench for csr_exec_unit
// Covers the CSR_COUNTER_EN build when that macro is defined, else the counter-absent build.
module tb_csr_exec_unit;

  localparam logic [63:0] MISA = 64'h8000_0000_0014_1101;
  localparam logic [2:0] OP_RW = 3'd1, OP_RS = 3'd2, OP_RC = 3'd3, OP_RSI = 3'd6, OP_RCI = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_en = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_op = '0;
  logic [11:0] issue_csrid = '0;
  logic [4:0]  issue_imm = '0;
  logic        issue_src_zero = 1'b0;
  logic [63:0] issue_rdata = '0;
  logic [6:0]  issue_rd = '0;
  logic        issue_we = 1'b0;
  logic [6:0]  issue_rob_idx = '0;
  logic        redirect = 1'b0;
  logic [6:0]  redirect_idx = '0;
  logic [2:0]  retire_cnt = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [6:0]  wb_rd;
  logic        wb_we;
  logic [63:0] wb_data;
  logic [6:0]  wb_rob_idx;
  logic        wb_exc;
  logic [3:0]  wb_exc_cause;

  int n_vec = 0;
  int n_err = 0;
  int r_lat;
  logic [63:0] r_data;
  logic        r_exc, r_we;
  logic [3:0]  r_cause;
  logic [6:0]  r_rd;

  csr_exec_unit dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_csrid(issue_csrid), .issue_imm(issue_imm), .issue_src_zero(issue_src_zero),
    .issue_rdata(issue_rdata), .issue_rd(issue_rd), .issue_we(issue_we),
    .issue_rob_idx(issue_rob_idx), .redirect(redirect), .redirect_idx(redirect_idx),
    .retire_cnt(retire_cnt), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_data(wb_data), .wb_rob_idx(wb_rob_idx), .wb_exc(wb_exc),
    .wb_exc_cause(wb_exc_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single cycle; returns one cycle after the capture edge.
  task automatic apply(input logic [2:0] op, input logic [11:0] id, input logic [4:0] imm,
                       input logic sz, input logic [63:0] rdata, input logic [6:0] rd,
                       input logic we, input logic [6:0] rob);
    int w = 0;
    while (!issue_ready && w < 10) begin
      step();
      w++;
    end
    if (!issue_ready) chk("issue_ready_timeout", 64'(issue_ready), 64'd1);
    issue_op = op; issue_csrid = id; issue_imm = imm; issue_src_zero = sz;
    issue_rdata = rdata; issue_rd = rd; issue_we = we; issue_rob_idx = rob;
    issue_en = 1'b1;
    step();
    issue_en = 1'b0;
  endtask

  // r_lat counts cycles from the issue cycle to the first cycle wb_valid is seen.
  task automatic wait_wb();
    r_lat = 1;
    while (!wb_valid && r_lat < 10) begin
      step();
      r_lat++;
    end
    if (!wb_valid) chk("wb_valid_timeout", 64'(wb_valid), 64'd1);
    r_data = wb_data; r_exc = wb_exc; r_cause = wb_exc_cause; r_we = wb_we; r_rd = wb_rd;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [11:0] id, input logic [4:0] imm,
                        input logic sz, input logic [63:0] rdata, input logic [6:0] rd,
                        input logic we, input logic [6:0] rob);
    apply(op, id, imm, sz, rdata, rd, we, rob);
    wait_wb();
    step();
  endtask

  task automatic rd_csr(input logic [11:0] id);
    run_op(OP_RS, id, 5'd0, 1'b1, 64'd0, 7'd1, 1'b1, 7'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef CSR_COUNTER_EN
    retire_cnt = 3'd2;
`endif
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_wb_exc", {wb_exc, wb_exc_cause}, 64'd0);

`ifdef CSR_COUNTER_EN
    repeat (10) step();
    retire_cnt = 3'd0;
    rd_csr(12'hB02);
    chk("minstret_after_10x2", r_data, 64'd20);
    run_op(OP_RW, 12'hB00, 5'd0, 1'b0, 64'd100, 7'd2, 1'b0, 7'd0);
    rd_csr(12'hB00);
    chk("mcycle_after_write", r_data, 64'd102);
`else
    rd_csr(12'hB00);
    chk("mcycle_absent_exc", {r_exc, r_cause}, {1'b1, 4'd2});
    run_op(OP_RW, 12'hB02, 5'd0, 1'b0, 64'd5, 7'd2, 1'b1, 7'd0);
    chk("minstret_absent_exc", {r_exc, r_we}, {1'b1, 1'b0});
`endif

    run_op(OP_RW, 12'h340, 5'd0, 1'b0, 64'h1234, 7'd5, 1'b1, 7'd3);
    chk("rw_latency", 64'(r_lat), 64'd2);
    chk("rw_old", r_data, 64'd0);
    chk("rw_we_rd", {r_we, r_exc, r_rd}, {1'b1, 1'b0, 7'd5});
    rd_csr(12'h340);
    chk("rs_zero_read", r_data, 64'h1234);
    rd_csr(12'h340);
    chk("rs_zero_no_write", r_data, 64'h1234);

    run_op(OP_RW, 12'h340, 5'd0, 1'b0, 64'hF0, 7'd5, 1'b1, 7'd4);
    run_op(OP_RCI, 12'h340, 5'h10, 1'b0, 64'hFFFF, 7'd5, 1'b1, 7'd5);
    chk("rci_old", r_data, 64'hF0);
    run_op(OP_RSI, 12'h340, 5'h00, 1'b0, 64'hFFFF, 7'd5, 1'b1, 7'd6);
    chk("rsi0_old", r_data, 64'hE0);
    rd_csr(12'h340);
    chk("rsi0_no_write", r_data, 64'hE0);
    run_op(OP_RC, 12'h340, 5'd0, 1'b0, 64'h20, 7'd5, 1'b1, 7'd7);
    run_op(OP_RS, 12'h340, 5'd0, 1'b0, 64'h3, 7'd5, 1'b1, 7'd8);
    chk("rc_then_rs_old", r_data, 64'hC0);
    rd_csr(12'h340);
    chk("rs_result", r_data, 64'hC3);

    run_op(OP_RW, 12'hF14, 5'd0, 1'b0, 64'h55, 7'd6, 1'b1, 7'd9);
    chk("hartid_write_exc", {r_exc, r_cause, r_we}, {1'b1, 4'd2, 1'b0});
    chk("hartid_write_data", r_data, 64'd0);
    rd_csr(12'hF14);
    chk("hartid_read", {r_exc, r_data}, {1'b0, 64'd0});
    run_op(OP_RS, 12'hF14, 5'd0, 1'b0, 64'd0, 7'd6, 1'b1, 7'd9);
    chk("hartid_rs_nonx0_exc", 64'(r_exc), 64'd1);

    run_op(OP_RW, 12'h305, 5'd0, 1'b0, '1, 7'd2, 1'b1, 7'd10);
    rd_csr(12'h305);
    chk("mtvec_bit1", r_data, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_RW, 12'h341, 5'd0, 1'b0, '1, 7'd2, 1'b1, 7'd11);
    rd_csr(12'h341);
    chk("mepc_bit0", r_data, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(OP_RW, 12'h342, 5'd0, 1'b0, 64'hA5, 7'd2, 1'b1, 7'd12);
    rd_csr(12'h342);
    chk("mcause_rw", r_data, 64'hA5);
    run_op(OP_RW, 12'h301, 5'd0, 1'b0, 64'd0, 7'd2, 1'b1, 7'd13);
    chk("misa_write_ignored", {r_exc, r_data}, {1'b0, MISA});
    rd_csr(12'h301);
    chk("misa_read", r_data, MISA);
    rd_csr(12'h7C0);
    chk("unimpl_exc", {r_exc, r_cause, r_data}, {1'b1, 4'd2, 64'd0});

    // Kill in EXEC with redirect_idx equal to the op index.
    apply(OP_RW, 12'h340, 5'd0, 1'b0, 64'h5555, 7'd3, 1'b1, 7'd10);
    redirect = 1'b1; redirect_idx = 7'd10;
    step();
    redirect = 1'b0;
    chk("kill_exec_ready", 64'(issue_ready), 64'd1);
    chk("kill_exec_no_wb", 64'(wb_valid), 64'd0);
    step();
    chk("kill_exec_no_wb_later", 64'(wb_valid), 64'd0);
    rd_csr(12'h340);
    chk("kill_exec_mscratch", r_data, 64'hC3);

    // Kill in IDLE: op dropped, unit stays ready.
    redirect = 1'b1; redirect_idx = 7'd20;
    issue_op = OP_RW; issue_csrid = 12'h340; issue_rdata = 64'h66; issue_rob_idx = 7'd20;
    issue_en = 1'b1;
    step();
    issue_en = 1'b0; redirect = 1'b0;
    chk("kill_idle_ready", 64'(issue_ready), 64'd1);
    rd_csr(12'h340);
    chk("kill_idle_mscratch", r_data, 64'hC3);

    // Redirect younger across wrap: op {0,63}, redirect {1,2} -> op survives.
    apply(OP_RW, 12'h340, 5'd0, 1'b0, 64'h77, 7'd4, 1'b1, 7'h3F);
    redirect = 1'b1; redirect_idx = 7'h42;
    wait_wb();
    redirect = 1'b0;
    step();
    chk("wrap_survive_old", r_data, 64'hC3);
    rd_csr(12'h340);
    chk("wrap_survive_new", r_data, 64'h77);

    // Backpressure: WB held for 5 cycles, redirect ignored meanwhile.
    wb_ready = 1'b0;
    apply(OP_RS, 12'h340, 5'd0, 1'b1, 64'd0, 7'd9, 1'b1, 7'h11);
    wait_wb();
    redirect = 1'b1; redirect_idx = 7'h11;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 64'(wb_valid), 64'd1);
      chk("hold_payload", {wb_data[31:0], wb_rd, wb_rob_idx, wb_we}, {32'h77, 7'd9, 7'h11, 1'b1});
      chk("hold_not_ready", 64'(issue_ready), 64'd0);
    end
    redirect = 1'b0;
    wb_ready = 1'b1;
    step();
    chk("release_ready", 64'(issue_ready), 64'd1);
    chk("release_valid", 64'(wb_valid), 64'd0);

    // Reset in the middle of an op abandons it and clears CSRs.
    apply(OP_RW, 12'h340, 5'd0, 1'b0, 64'h99, 7'd4, 1'b1, 7'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_no_wb", 64'(wb_valid), 64'd0);
    chk("midrst_ready", 64'(issue_ready), 64'd1);
    rd_csr(12'h340);
    chk("midrst_mscratch", r_data, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_exec_unit.md
# csr_exec_unit

Execution end of the CSR issue path: accepts one CSR instruction at a time from the CSR issue queue, performs the atomic read-modify-write on a small machine-mode CSR file, and returns the old CSR value for writeback to the register file. Ops arrive only when the instruction is at the ROB commit head. A 3-state FSM serializes each op through capture, execute and writeback-handshake. Redirects kill uncommitted side effects.

## Interface
- XLEN, 64, data width
- PREG_WIDTH, 7, physical register index width
- ROB_WIDTH, 6, ROB index bits; rob_idx fields are ROB_WIDTH+1 bits, MSB is wrap direction
- HART_ID, 0, value returned by mhartid
- MISA_VAL, 64'h8000_0000_0014_1101, value returned by misa

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_en  in  1  op valid
- issue_ready  out  1  unit can accept op
- issue_op  in  3  funct3: 1 RW, 2 RS, 3 RC, 5 RWI, 6 RSI, 7 RCI
- issue_csrid  in  12  CSR address
- issue_imm  in  5  uimm for I-forms
- issue_src_zero  in  1  architectural rs1 is x0
- issue_rdata  in  XLEN  rs1 operand value
- issue_rd  in  PREG_WIDTH  destination preg
- issue_we  in  1  rd is not x0
- issue_rob_idx  in  ROB_WIDTH+1  op ROB index
- redirect  in  1  backend flush
- redirect_idx  in  ROB_WIDTH+1  flush point
- retire_cnt  in  3  instructions retired this cycle
- wb_valid  out  1  writeback valid
- wb_ready  in  1  writeback accepted
- wb_rd  out  PREG_WIDTH; wb_we  out  1; wb_data  out  XLEN; wb_rob_idx  out  ROB_WIDTH+1
- wb_exc  out  1  illegal-instruction exception
- wb_exc_cause  out  4  2 when wb_exc, else 0

## Operation
- FSM states IDLE, EXEC, WB. issue_ready = (state==IDLE).
- IDLE: on issue_en && issue_ready && !kill, capture all issue_* into registers, go EXEC. Killed ops are dropped and stay IDLE.
- kill = redirect && !older(op_idx, redirect_idx).
- older(a,b) = (a.msb != b.msb) ? a.idx > b.idx : a.idx < b.idx. Equal indices are not older, so the op is killed.
- EXEC, when killed: no CSR write, go IDLE.
- EXEC, otherwise:
  - src = I-form ? zero-extended imm : rdata.
  - new = RW: src; RS: old|src; RC: old & ~src.
  - Write suppressed when op is RS/RC/RSI/RCI and src-zero holds: issue_src_zero for RS/RC, imm==0 for I-forms.
  - Illegal when address unimplemented, or when a write is not suppressed and csrid[11:10]==2'b11. Illegal: no write, wb_exc=1, wb_data=0, wb_we=0.
  - Legal: write new, wb_data=old, wb_we=issue_we.
  - Go WB.
- WB: wb_valid=1 with stable payload until wb_ready. On wb_ready go IDLE. Redirect is ignored in WB, because the side effect is already architectural.
- CSR file:
  - mtvec 0x305, bit1 reads 0.
  - mscratch 0x340.
  - mepc 0x341, bit0 reads 0.
  - mcause 0x342.
  - misa 0x301, read-only; writes are ignored silently since its address is not in the 2'b11 range.
  - mhartid 0xF14, read-only.
- Reset: state IDLE; all CSRs 0 except constants; wb_valid=0, wb_exc=0, all wb payload 0, issue_ready=1 from first post-reset cycle.
- rst asserted mid-op: op abandoned, no writeback, CSR values reset.

## Timing
- Op captured cycle T, EXEC T+1 (CSR write visible T+2), wb_valid earliest T+2.
- With wb_ready held high: issue_ready returns T+3, so throughput is one op per 3 cycles.
- wb_ready low holds WB indefinitely; issue_ready stays 0.
- Counters (when compiled in): mcycle +1 every cycle; minstret += retire_cnt every cycle; a CSR write in EXEC overrides the increment that cycle. Both wrap modulo 2^XLEN.
- Reads in EXEC see the value before that cycle's increment.

## Configuration
- CSR_COUNTER_EN defined: mcycle 0xB00 and minstret 0xB02 implemented, read/write, per Timing.
- CSR_COUNTER_EN undefined: counters absent, addresses 0xB00/0xB02 are unimplemented, so any access raises wb_exc with cause 2; retire_cnt is ignored.

## Test plan
- mscratch=0; CSRRW 0x340, rdata=0x1234, issue_we=1 -> wb_valid at T+2, wb_data=0, and a following CSRRS with src_zero reads 0x1234 with mscratch unchanged.
- mscratch=0xF0; CSRRCI imm=0x10 -> wb_data=0xF0, new mscratch=0xE0; CSRRSI imm=0 -> no write.
- CSRRW to 0xF14 -> wb_exc=1, wb_exc_cause=2, wb_we=0; CSRRS src_zero to 0xF14 -> wb_data=HART_ID, no exception.
- redirect in EXEC with redirect_idx==op idx -> mscratch unchanged, no wb_valid, issue_ready=1 next cycle. Repeat with redirect_idx younger across wrap: op idx {0,63}, redirect {1,2} -> op completes.
- wb_ready low 5 cycles -> wb_valid and payload stable, issue_ready=0; wb_ready high -> IDLE next cycle.
- CSR_COUNTER_EN on: retire_cnt=2 for 10 cycles after reset, then read minstret -> 20. Write mcycle=100 -> next read is 100 + elapsed cycles. Counters off: access 0xB00 -> wb_exc=1.
